multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 One clock and one reset: synchronous, active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 op  in  7  instruction opcode; funct3  in  3; funct7b5  in  1  (instr bit 30).
REQ-005 Zero  in  1  ALU zero flag, valid in the BEQ cycle.
REQ-006 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/selects.
REQ-007 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-008 ALUControl  out  3  encodings: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SLT.

Function
REQ-009 Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-010 Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-011 Transitions: FETCH->DECODE. DECODE->MEMADR (lw/sw), EXECUTER, EXECUTEI, BEQ, JAL by opcode, else FETCH.
REQ-012 MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-013 Unlisted outputs are 0 in each state. FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01. MEMADR: ALUSrcA=10, ALUSrcB=01.
REQ-015 MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: AdrSrc=1, MemWrite=1.
REQ-016 EXECUTER: ALUSrcA=10, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-017 ALUWB: RegWrite=1. JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1. BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-018 PCWrite = PCUpdate OR (Branch AND Zero); combinational in the same cycle as Zero.
REQ-019 ALU decode: ALUOp 00 -> ADD; 01 -> SUB.
REQ-020 ALUOp 10, funct3 000 -> SUB if op[5] AND funct7b5, else ADD. This keeps addi as ADD for any immediate.
REQ-021 ALUOp 10: funct3 001 -> SLL (sll and slli); 010 -> SLT; 110 -> OR; 111 -> AND; any other funct3 -> ADD.
REQ-022 ImmSrc is decoded from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
REQ-023 Each instruction's latency is fixed: lw 5, sw 4, R/I-ALU 4, jal 4, beq 3 cycles; unsupported opcode 2 cycles.
REQ-024 op, funct3 and funct7b5 change only after an IRWrite cycle. The controller does not latch them.

Reset
REQ-025 While rst_n=0 at a rising clk, the state becomes FETCH. Reset wins over any transition, including mid-instruction (e.g. in MEMWRITE).
REQ-026 All outputs are combinational from state plus inputs. In the cycle after reset they show the FETCH values, and MemWrite and RegWrite are 0.

Structure
REQ-027 A shared package holds: the state enum, the ALUControl encoding constants, the ALUOp type, and the opcode constants.
REQ-028 One sub-module, alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl), is instantiated in the top module. The FSM stays in the top module.

Verification
REQ-029 Reset: hold rst_n=0 for 2 cycles, then release -> state FETCH; IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0.
REQ-030 lw (op 0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5.
REQ-031 beq with Zero=1 in cycle 3 -> PCWrite=1 and ALUControl=001. Repeat with Zero=0 -> PCWrite=0; back in FETCH in cycle 4.
REQ-032 R-type decode: funct3 000, funct7b5=1 -> 001 (sub). funct3 001 -> 100 (sll). funct3 010 -> 101 (slt). I-ALU funct3 000, funct7b5=1 -> 000 (addi).
REQ-033 sw: drop rst_n in the MEMWRITE cycle -> MemWrite is gated only by the state that cycle, and the next state is FETCH. Unsupported op 1110011 -> FETCH after DECODE with no write enables.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RISC-V controller:
// FSM state encoding, ALUOp codes, ALUControl encodings and opcodes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // 2'b11 is never produced by the FSM; the decoder treats it as ADD.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to the ALUControl code.
// Only R-type (op[5]=1) with funct7b5 set selects SUB for funct3 000, so
// addi stays ADD whatever bit 30 of its immediate happens to be.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t     i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  // Combinational decode of the ALU operation.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing the shared datapath,
// immediate-format decode and the ALU decoder instance.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction, write IR, PC <= PC + 4
// DECODE   | read registers, compute PC + imm for a possible branch
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | read data memory at computed address
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECUTER | ALU op on rs1, rs2
// EXECUTEI | ALU op on rs1, imm
// ALUWB    | write ALU result to rd
// BEQ      | compare rs1, rs2; take branch when Zero
// JAL      | PC <= target, compute PC + 4 for link
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);

  state_t r_state;
  state_t w_next_state;
  logic   w_pc_update;
  logic   w_branch;
  aluop_t w_alu_op;

  // State register; reset is synchronous and overrides any transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYP:      w_next_state = S_EXECUTER;
          OP_IALU:      w_next_state = S_EXECUTEI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      S_JAL:      w_next_state = S_ALUWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = S_FETCH;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Moore outputs: everything defaults to 0 and each state raises its own.
  always_comb begin
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      default: begin
        IRWrite = 1'b0;
      end
    endcase
  end

  // Zero arrives in the BEQ cycle itself, so the branch term stays combinational.
  assign PCWrite = w_pc_update | (w_branch & Zero);

  // Immediate format follows the opcode in every state, not just DECODE.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_IALU: ImmSrc = 2'b00;
      OP_SW:          ImmSrc = 2'b01;
      OP_BEQ:         ImmSrc = 2'b10;
      OP_JAL:         ImmSrc = 2'b11;
      default:        ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (ALUControl)
  );

endmodule
